// File: rtl/tetris_pkg.sv
// Shared constants and enums for the falling-piece move controller.
package tetris_pkg;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;
  localparam int OFF_W       = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHAPE  = 3'd1,
    S_CHK0   = 3'd2,
    S_CHK1   = 3'd3,
    S_CHK2   = 3'd4,
    S_CHK3   = 3'd5,
    S_DECIDE = 3'd6
  } state_t;

  // Values double as bit indices into the pending-request vector.
  typedef enum logic [2:0] {
    REQ_SPAWN  = 3'd0,
    REQ_DROP   = 3'd1,
    REQ_ROTATE = 3'd2,
    REQ_LEFT   = 3'd3,
    REQ_RIGHT  = 3'd4
  } req_t;

endpackage

// File: rtl/tetron_bounds_check.sv
// Adds a signed shaper offset to a candidate pivot and flags cells outside the board.
module tetron_bounds_check
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF
) (
  input  logic [4:0]       cand_row,
  input  logic [3:0]       cand_col,
  input  logic [OFF_W-1:0] voff,
  input  logic [OFF_W-1:0] hoff,
  output logic [4:0]       row,
  output logic [3:0]       col,
  output logic             out_of_range
);

  logic signed [5:0] row_sum;
  logic signed [5:0] col_sum;

  assign row_sum = $signed({1'b0, cand_row}) + $signed({voff[OFF_W-1], voff});
  assign col_sum = $signed({2'b00, cand_col}) + $signed({hoff[OFF_W-1], hoff});

  // Sign bit catches negative coordinates; low bits are the magnitude otherwise.
  assign out_of_range = row_sum[5] | col_sum[5] |
                        (row_sum[4:0] >= 5'(BOARD_H)) |
                        (col_sum[4:0] >= 5'(BOARD_W));

  assign row = row_sum[4:0];
  assign col = col_sum[3:0];

endmodule

// File: rtl/tetron_move_ctrl.sv
// Arbitrates piece move requests, collision-checks the four shaped blocks
// against the board one per cycle, then commits, rejects, locks or fails the spawn.
module tetron_move_ctrl
  import tetris_pkg::*;
#(
  parameter int BOARD_W   = BOARD_W_DEF,
  parameter int BOARD_H   = BOARD_H_DEF,
  parameter int SPAWN_COL = 4,
  parameter int SPAWN_ROW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spawn,
  input  logic             req_left,
  input  logic             req_right,
  input  logic             req_rotate,
  input  logic             req_drop,
  output logic             shp_active,
  output logic [2:0]       shp_rotation,
  input  logic [OFF_W-1:0] blk1_voff,
  input  logic [OFF_W-1:0] blk1_hoff,
  input  logic [OFF_W-1:0] blk2_voff,
  input  logic [OFF_W-1:0] blk2_hoff,
  input  logic [OFF_W-1:0] blk3_voff,
  input  logic [OFF_W-1:0] blk3_hoff,
  input  logic [OFF_W-1:0] blk4_voff,
  input  logic [OFF_W-1:0] blk4_hoff,
  output logic             brd_rd_en,
  output logic [4:0]       brd_rd_row,
  output logic [3:0]       brd_rd_col,
  input  logic             brd_rd_data,
  output logic [4:0]       piece_row,
  output logic [3:0]       piece_col,
  output logic [2:0]       piece_rot,
  output logic             piece_valid,
  output logic             busy,
  output logic             lock,
  output logic             spawn_fail,
  output logic [2:0]       dbg_state
);

  // Requests are level-free pulses; each is held in a pending latch until the
  // FSM is back in IDLE. Board reads are strobe/response: data arrives one
  // cycle after brd_rd_en with no back-pressure.

  state_t     state, state_next;
  req_t       cur_req, acc_type;
  logic       accept;
  logic [4:0] pend, pend_next, req_vec;
  logic [4:0] cand_row;
  logic [3:0] cand_col;
  logic [2:0] cand_rot;
  logic       hit, hit_now, rd_pend, lock_evt, in_chk;

  logic [OFF_W-1:0] sel_voff, sel_hoff;
  logic [4:0]       chk_row;
  logic [3:0]       chk_col;
  logic             chk_oor;

  tetron_bounds_check #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H)
  ) u_bounds (
    .cand_row     (cand_row),
    .cand_col     (cand_col),
    .voff         (sel_voff),
    .hoff         (sel_hoff),
    .row          (chk_row),
    .col          (chk_col),
    .out_of_range (chk_oor)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    acc_type   = REQ_SPAWN;
    req_vec    = pend | {req_right, req_left, req_rotate, req_drop, spawn};

    if (state == S_IDLE) begin
      if (!piece_valid) begin
        if (req_vec[REQ_SPAWN]) begin
          accept   = 1'b1;
          acc_type = REQ_SPAWN;
        end
      end else if (req_vec[REQ_DROP]) begin
        accept   = 1'b1;
        acc_type = REQ_DROP;
      end else if (req_vec[REQ_ROTATE]) begin
        accept   = 1'b1;
        acc_type = REQ_ROTATE;
      end else if (req_vec[REQ_LEFT]) begin
        accept   = 1'b1;
        acc_type = REQ_LEFT;
      end else if (req_vec[REQ_RIGHT]) begin
        accept   = 1'b1;
        acc_type = REQ_RIGHT;
      end
    end

    case (state)
      S_IDLE:   if (accept) state_next = S_SHAPE;
      S_SHAPE:  state_next = S_CHK0;
      S_CHK0:   state_next = S_CHK1;
      S_CHK1:   state_next = S_CHK2;
      S_CHK2:   state_next = S_CHK3;
      S_CHK3:   state_next = S_DECIDE;
      S_DECIDE: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase

    sel_voff = blk1_voff;
    sel_hoff = blk1_hoff;
    case (state)
      S_CHK1: begin sel_voff = blk2_voff; sel_hoff = blk2_hoff; end
      S_CHK2: begin sel_voff = blk3_voff; sel_hoff = blk3_hoff; end
      S_CHK3: begin sel_voff = blk4_voff; sel_hoff = blk4_hoff; end
      default: ;
    endcase

    in_chk     = (state == S_CHK0) || (state == S_CHK1) ||
                 (state == S_CHK2) || (state == S_CHK3);
    brd_rd_en  = in_chk && !chk_oor;
    brd_rd_row = brd_rd_en ? chk_row : 5'd0;
    brd_rd_col = brd_rd_en ? chk_col : 4'd0;

    hit_now  = hit | (rd_pend & brd_rd_data);
    lock_evt = (state == S_DECIDE) && hit_now && (cur_req == REQ_DROP);

    pend_next = req_vec;
    if (accept) pend_next[acc_type] = 1'b0;
    if ((accept && acc_type == REQ_SPAWN) || lock_evt || !piece_valid) pend_next = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cur_req     <= REQ_SPAWN;
      pend        <= '0;
      cand_row    <= '0;
      cand_col    <= '0;
      cand_rot    <= '0;
      hit         <= 1'b0;
      rd_pend     <= 1'b0;
      piece_row   <= '0;
      piece_col   <= '0;
      piece_rot   <= '0;
      piece_valid <= 1'b0;
      lock        <= 1'b0;
      spawn_fail  <= 1'b0;
    end else begin
      state      <= state_next;
      pend       <= pend_next;
      lock       <= 1'b0;
      spawn_fail <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            cur_req  <= acc_type;
            hit      <= 1'b0;
            rd_pend  <= 1'b0;
            cand_row <= piece_row;
            cand_col <= piece_col;
            cand_rot <= piece_rot;
            case (acc_type)
              REQ_SPAWN: begin
                cand_row <= 5'(SPAWN_ROW);
                cand_col <= 4'(SPAWN_COL);
                cand_rot <= 3'd0;
              end
              REQ_DROP:   cand_row <= piece_row + 5'd1;
              REQ_ROTATE: cand_rot <= {1'b0, piece_rot[1:0] + 2'd1};
              REQ_LEFT:   cand_col <= piece_col - 4'd1;
              REQ_RIGHT:  cand_col <= piece_col + 4'd1;
              default: ;
            endcase
          end
        end
        S_CHK0, S_CHK1, S_CHK2, S_CHK3: begin
          hit     <= hit_now | chk_oor;
          rd_pend <= brd_rd_en;
        end
        S_DECIDE: begin
          if (!hit_now) begin
            piece_row <= cand_row;
            piece_col <= cand_col;
            piece_rot <= cand_rot;
            if (cur_req == REQ_SPAWN) piece_valid <= 1'b1;
          end else if (cur_req == REQ_DROP) begin
            lock        <= 1'b1;
            piece_valid <= 1'b0;
          end else if (cur_req == REQ_SPAWN) begin
            spawn_fail <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state != S_IDLE);
  assign shp_active   = piece_valid | busy;
  assign shp_rotation = busy ? cand_rot : piece_rot;
  assign dbg_state    = state;

endmodule

// File: tb/tb_tetron_move_ctrl.sv
// Directed bench for tetron_move_ctrl with a T-piece shaper model and a board occupancy model.
module tb_tetron_move_ctrl;
  import tetris_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       spawn, req_left, req_right, req_rotate, req_drop;
  logic       shp_active;
  logic [2:0] shp_rotation;
  logic [4:0] blk1_voff, blk1_hoff, blk2_voff, blk2_hoff;
  logic [4:0] blk3_voff, blk3_hoff, blk4_voff, blk4_hoff;
  logic       brd_rd_en;
  logic [4:0] brd_rd_row;
  logic [3:0] brd_rd_col;
  logic       brd_rd_data;
  logic [4:0] piece_row;
  logic [3:0] piece_col;
  logic [2:0] piece_rot;
  logic       piece_valid, busy, lock, spawn_fail;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] Z = 5'd0, P = 5'd1, M = 5'h1f;
  localparam logic [4:0] M_SPAWN = 5'b00001, M_DROP = 5'b00010, M_ROT = 5'b00100;
  localparam logic [4:0] M_LEFT = 5'b01000, M_RIGHT = 5'b10000;

  logic [4:0] tv [4][4];
  logic [4:0] th [4][4];
  logic [4:0] sv [4];
  logic [4:0] sh [4];
  logic       board [20][10];

  tetron_move_ctrl dut (
    .clk (clk), .rst (rst), .spawn (spawn),
    .req_left (req_left), .req_right (req_right),
    .req_rotate (req_rotate), .req_drop (req_drop),
    .shp_active (shp_active), .shp_rotation (shp_rotation),
    .blk1_voff (blk1_voff), .blk1_hoff (blk1_hoff),
    .blk2_voff (blk2_voff), .blk2_hoff (blk2_hoff),
    .blk3_voff (blk3_voff), .blk3_hoff (blk3_hoff),
    .blk4_voff (blk4_voff), .blk4_hoff (blk4_hoff),
    .brd_rd_en (brd_rd_en), .brd_rd_row (brd_rd_row),
    .brd_rd_col (brd_rd_col), .brd_rd_data (brd_rd_data),
    .piece_row (piece_row), .piece_col (piece_col), .piece_rot (piece_rot),
    .piece_valid (piece_valid), .busy (busy), .lock (lock),
    .spawn_fail (spawn_fail), .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // T-piece shaper: registered lookup of (voff, hoff) per rotation and block.
  initial begin
    tv[0] = '{Z, Z, Z, M}; th[0] = '{M, Z, P, Z};
    tv[1] = '{M, Z, P, Z}; th[1] = '{Z, Z, Z, P};
    tv[2] = '{Z, Z, Z, P}; th[2] = '{M, Z, P, Z};
    tv[3] = '{M, Z, P, Z}; th[3] = '{Z, Z, Z, M};
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) board[r][c] = 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin sv[b] <= Z; sh[b] <= Z; end
    end else begin
      for (int b = 0; b < 4; b++) begin
        sv[b] <= tv[shp_rotation[1:0]][b];
        sh[b] <= th[shp_rotation[1:0]][b];
      end
    end
  end

  assign blk1_voff = sv[0]; assign blk1_hoff = sh[0];
  assign blk2_voff = sv[1]; assign blk2_hoff = sh[1];
  assign blk3_voff = sv[2]; assign blk3_hoff = sh[2];
  assign blk4_voff = sv[3]; assign blk4_hoff = sh[3];

  // Board read port: one-cycle read latency.
  always @(posedge clk or posedge rst) begin
    if (rst) brd_rd_data <= 1'b0;
    else if (brd_rd_en && brd_rd_row < 5'd20 && brd_rd_col < 4'd10)
      brd_rd_data <= board[brd_rd_row][brd_rd_col];
    else brd_rd_data <= 1'b0;
  end

  // Driver and check tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [4:0] m);
    {req_right, req_left, req_rotate, req_drop, spawn} = m;
    @(posedge clk); #1;
    {req_right, req_left, req_rotate, req_drop, spawn} = 5'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(n < 30), 32'd1);
  endtask

  task automatic do_req(input logic [4:0] m, input string tag);
    pulse(m);
    wait_idle(tag);
  endtask

  task automatic check_piece(input string tag, input int r, input int c, input int rot);
    check({tag, "_row"}, 32'(piece_row), 32'(r));
    check({tag, "_col"}, 32'(piece_col), 32'(c));
    check({tag, "_rot"}, 32'(piece_rot), 32'(rot));
  endtask

  initial begin
    int exp_col [5];
    exp_col = '{3, 2, 1, 1, 1};
    rst = 1'b1;
    {req_right, req_left, req_rotate, req_drop, spawn} = 5'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(piece_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_shp_active", 32'(shp_active), 32'd0);
    check("rst_rd_en", 32'(brd_rd_en), 32'd0);
    check("rst_lock", 32'(lock), 32'd0);
    check_piece("rst", 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: spawn on empty board, exact 6-edge latency
    pulse(M_SPAWN);
    check("spawn_busy", 32'(busy), 32'd1);
    check("spawn_shp_active", 32'(shp_active), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("spawn_not_yet", 32'(piece_valid), 32'd0);
    @(posedge clk); #1;
    check("spawn_valid", 32'(piece_valid), 32'd1);
    check("spawn_no_fail", 32'(spawn_fail), 32'd0);
    check_piece("spawn", 1, 4, 0);
    @(posedge clk); #1;
    check("spawn_idle", 32'(busy), 32'd0);

    // 2: left x5, wall at col 0 rejects; then one right
    for (int i = 0; i < 5; i++) begin
      do_req(M_LEFT, "left_wait");
      check("left_col", 32'(piece_col), 32'(exp_col[i]));
    end
    check("left_valid", 32'(piece_valid), 32'd1);
    do_req(M_RIGHT, "right_wait");
    check_piece("right", 1, 2, 0);

    // 3: rotate x4 with wrap; shaper follows committed rotation
    for (int i = 0; i < 4; i++) begin
      do_req(M_ROT, "rot_wait");
      check("rot_val", 32'(piece_rot), 32'((i + 1) % 4));
      check("rot_shp", 32'(shp_rotation), 32'((i + 1) % 4));
      @(posedge clk); #1;
      check("rot_blk4_hoff", 32'(blk4_hoff), 32'(th[(i + 1) % 4][3]));
    end

    // 4: full row 10 stops the piece at row 9, next drop locks
    for (int c = 0; c < 10; c++) board[10][c] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_req(M_DROP, "drop_wait");
      check("drop_row", 32'(piece_row), 32'(2 + i));
    end
    pulse(M_DROP);
    repeat (5) @(posedge clk);
    #1;
    check("lock_not_yet", 32'(lock), 32'd0);
    @(posedge clk); #1;
    check("lock_pulse", 32'(lock), 32'd1);
    check("lock_valid", 32'(piece_valid), 32'd0);
    check("lock_row", 32'(piece_row), 32'd9);
    @(posedge clk); #1;
    check("lock_end", 32'(lock), 32'd0);
    for (int c = 0; c < 10; c++) board[10][c] = 1'b0;

    // 5: drop beats left while busy; duplicate left coalesces
    do_req(M_SPAWN, "respawn_wait");
    check_piece("respawn", 1, 4, 0);
    pulse(M_ROT);
    pulse(M_LEFT | M_DROP);
    @(posedge clk); #1;
    pulse(M_LEFT);
    wait_idle("arb_wait");
    check_piece("arb_rot", 1, 4, 1);
    repeat (7) @(posedge clk);
    #1;
    check_piece("arb_drop", 2, 4, 1);
    repeat (7) @(posedge clk);
    #1;
    check_piece("arb_left", 2, 3, 1);
    check("arb_idle", 32'(busy), 32'd0);
    repeat (14) @(posedge clk);
    #1;
    check("coalesce_col", 32'(piece_col), 32'd3);

    // 6: blocked spawn cell, then reset during CHK2
    rst = 1'b1;
    #1;
    check("rst2_valid", 32'(piece_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    board[1][4] = 1'b1;
    pulse(M_SPAWN);
    repeat (5) @(posedge clk);
    #1;
    check("sfail_not_yet", 32'(spawn_fail), 32'd0);
    @(posedge clk); #1;
    check("sfail_pulse", 32'(spawn_fail), 32'd1);
    check("sfail_valid", 32'(piece_valid), 32'd0);
    @(posedge clk); #1;
    check("sfail_end", 32'(spawn_fail), 32'd0);
    board[1][4] = 1'b0;

    pulse(M_SPAWN);
    repeat (3) @(posedge clk);
    #1;
    check("mid_state", 32'(dbg_state), 32'(S_CHK2));
    check("mid_rd_en", 32'(brd_rd_en), 32'd1);
    check("mid_rd_col", 32'(brd_rd_col), 32'd5);
    rst = 1'b1;
    #1;
    check("abort_rd_en", 32'(brd_rd_en), 32'd0);
    check("abort_rd_col", 32'(brd_rd_col), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_shp_active", 32'(shp_active), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_commit", 32'(piece_valid), 32'd0);
    check_piece("abort", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
